// File: rtl/writeback_unit_if.sv
// Purpose: bundles the execute, data-memory and register-file signals of the writeback stage.
// Latency: none; wiring only.
// Backpressure: o_stall travels upstream to hold the execute stage while a load is outstanding.
// Ports: master = execute/memory/regfile side, slave = writeback_unit.
interface writeback_unit_if;
  logic        i_valid;
  logic [4:0]  i_rd;
  logic [31:0] i_result;
  logic        i_is_load;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lo;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;
  logic        o_wback;
  logic [4:0]  o_wreg;
  logic [31:0] o_wdata;
  logic        o_stall;
  logic [31:0] o_retired;

  modport master (
    output i_valid, i_rd, i_result, i_is_load, i_funct3, i_addr_lo,
    output i_mem_valid, i_mem_rdata,
    input  o_wback, o_wreg, o_wdata, o_stall, o_retired
  );

  modport slave (
    input  i_valid, i_rd, i_result, i_is_load, i_funct3, i_addr_lo,
    input  i_mem_valid, i_mem_rdata,
    output o_wback, o_wreg, o_wdata, o_stall, o_retired
  );
endinterface

// File: rtl/writeback_unit.sv
// Purpose: RV32 writeback stage; formats load data and drives register-file writes plus a retire count.
// Latency: 1 cycle from ALU acceptance or memory return to the o_wback pulse.
// Backpressure: o_stall is high for the whole time a load waits for memory; nothing is accepted then.
// Ports: clk, rst_n (async active-low); bus = writeback_unit_if.slave carrying all data/handshake signals.
module writeback_unit (
  input  logic              clk,
  input  logic              rst_n,
  writeback_unit_if.slave   bus
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state, state_nxt;
  logic        accept_alu, accept_ld, complete;

  logic [4:0]  pend_rd;
  logic [2:0]  pend_funct3;
  logic [1:0]  pend_addr_lo;

  logic        wback;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [31:0] retired;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and acceptance decode
  always_comb begin
    state_nxt  = state;
    accept_alu = 1'b0;
    accept_ld  = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_is_load) begin
            accept_ld = 1'b1;
            state_nxt = WAIT_MEM;
          end else begin
            accept_alu = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        // i_valid is deliberately ignored here; execute is being held by o_stall.
        if (bus.i_mem_valid) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load data formatting from the captured width code and address offset
  always_comb begin
    byte_sel = bus.i_mem_rdata[{pend_addr_lo, 3'b000} +: 8];
    half_sel = pend_addr_lo[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
    case (pend_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = bus.i_mem_rdata;
    endcase
  end

  // Pending load context, held for the whole memory wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rd      <= 5'd0;
      pend_funct3  <= 3'd0;
      pend_addr_lo <= 2'd0;
    end else if (accept_ld) begin
      pend_rd      <= bus.i_rd;
      pend_funct3  <= bus.i_funct3;
      pend_addr_lo <= bus.i_addr_lo;
    end
  end

  // Register-file write port; x0 writes are suppressed but still retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wback   <= 1'b0;
      wreg    <= 5'd0;
      wdata   <= 32'd0;
      retired <= 32'd0;
    end else begin
      wback <= 1'b0;
      if (accept_alu && (bus.i_rd != 5'd0)) begin
        wback <= 1'b1;
        wreg  <= bus.i_rd;
        wdata <= bus.i_result;
      end else if (complete && (pend_rd != 5'd0)) begin
        wback <= 1'b1;
        wreg  <= pend_rd;
        wdata <= load_data;
      end
      if (accept_alu || complete) retired <= retired + 32'd1;
    end
  end

  assign bus.o_wback   = wback;
  assign bus.o_wreg    = wreg;
  assign bus.o_wdata   = wdata;
  assign bus.o_retired = retired;
  assign bus.o_stall   = (state == WAIT_MEM);

endmodule

// File: tb/tb_writeback_unit.sv
// Purpose: directed plus random checking of writeback_unit against a transaction-level reference model.
// Latency: model predicts outputs one cycle after each applied input set.
// Backpressure: model tracks a single outstanding load and ignores new work while it is pending.
module tb_writeback_unit;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  writeback_unit_if bus ();

  writeback_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          m_busy;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_lo;
  logic        m_wback;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_retired;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    int unsigned sh;
    case (f3)
      3'd0, 3'd4: begin
        sh = 8 * lo;
        v  = (rdata >> sh) & 32'h0000_00FF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        sh = (lo >= 2'd2) ? 16 : 0;
        v  = (rdata >> sh) & 32'h0000_FFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("wback",   {31'd0, bus.o_wback}, {31'd0, m_wback});
    chk("wreg",    {27'd0, bus.o_wreg},  {27'd0, m_wreg});
    chk("wdata",   bus.o_wdata,          m_wdata);
    chk("stall",   {31'd0, bus.o_stall}, {31'd0, m_busy});
    chk("retired", bus.o_retired,        m_retired);
  endtask

  // Applies one cycle of inputs at a falling edge, advances the model, checks at the next falling edge.
  task automatic cycle(input bit v, input logic [4:0] rd, input logic [31:0] res, input bit ld,
                       input logic [2:0] f3, input logic [1:0] lo, input bit mv,
                       input logic [31:0] rdata);
    bus.i_valid     = v;
    bus.i_rd        = rd;
    bus.i_result    = res;
    bus.i_is_load   = ld;
    bus.i_funct3    = f3;
    bus.i_addr_lo   = lo;
    bus.i_mem_valid = mv;
    bus.i_mem_rdata = rdata;
    m_wback = 1'b0;
    if (!m_busy) begin
      if (v && !ld) begin
        m_retired++;
        if (rd != 0) begin
          m_wback = 1'b1; m_wreg = rd; m_wdata = res;
        end
      end else if (v && ld) begin
        m_busy = 1'b1; m_rd = rd; m_f3 = f3; m_lo = lo;
      end
    end else if (mv) begin
      m_busy = 1'b0;
      m_retired++;
      if (m_rd != 0) begin
        m_wback = 1'b1; m_wreg = m_rd; m_wdata = ref_load(m_f3, m_lo, rdata);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    m_busy = 0; m_rd = 0; m_f3 = 0; m_lo = 0;
    m_wback = 0; m_wreg = 0; m_wdata = 0; m_retired = 0;
  endtask

  task automatic idle_inputs();
    bus.i_valid = 0; bus.i_rd = 0; bus.i_result = 0; bus.i_is_load = 0;
    bus.i_funct3 = 0; bus.i_addr_lo = 0; bus.i_mem_valid = 0; bus.i_mem_rdata = 0;
  endtask

  initial begin
    logic [31:0] r_before;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // ALU op, rd=5
    cycle(1, 5'd5, 32'h1234, 0, 3'd0, 2'd0, 0, 32'd0);
    chk("alu_wdata_const", bus.o_wdata, 32'h0000_1234);
    chk("alu_retired_const", bus.o_retired, 32'd1);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 0, 32'd0);

    // LB, lane 3, memory returns three cycles after accept
    cycle(1, 5'd7, 32'd0, 1, 3'b000, 2'd3, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h80FF_0011);
    chk("lb_const", bus.o_wdata, 32'hFFFF_FF80);
    // LBU, same inputs
    cycle(1, 5'd7, 32'd0, 1, 3'b100, 2'd3, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h80FF_0011);
    chk("lbu_const", bus.o_wdata, 32'h0000_0080);

    // LH/LHU at offsets 2 and 0
    cycle(1, 5'd8, 32'd0, 1, 3'b001, 2'd2, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hFFFE_1234);
    chk("lh_hi_const", bus.o_wdata, 32'hFFFF_FFFE);
    cycle(1, 5'd8, 32'd0, 1, 3'b101, 2'd2, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hFFFE_1234);
    chk("lhu_hi_const", bus.o_wdata, 32'h0000_FFFE);
    cycle(1, 5'd9, 32'd0, 1, 3'b001, 2'd0, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hFFFE_1234);
    chk("lh_lo_const", bus.o_wdata, 32'h0000_1234);
    cycle(1, 5'd9, 32'd0, 1, 3'b101, 2'd0, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hFFFE_1234);
    chk("lhu_lo_const", bus.o_wdata, 32'h0000_1234);

    // rd=0 for an ALU op and a load
    r_before = bus.o_retired;
    cycle(1, 5'd0, 32'hDEAD_BEEF, 0, 3'd0, 2'd0, 0, 32'd0);
    cycle(1, 5'd0, 32'd0, 1, 3'b010, 2'd0, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hCAFE_F00D);
    chk("rd0_retired_delta", bus.o_retired - r_before, 32'd2);
    chk("rd0_wdata_held", bus.o_wdata, 32'h0000_1234);

    // i_valid held during the wait, then i_mem_valid pulsed while idle
    cycle(1, 5'd10, 32'd0, 1, 3'b010, 2'd0, 0, 32'd0);
    cycle(1, 5'd11, 32'h5555, 0, 3'd0, 2'd0, 0, 32'd0);
    cycle(1, 5'd12, 32'h6666, 1, 3'd0, 2'd0, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h0BAD_F00D);
    chk("lw_const", bus.o_wdata, 32'h0BAD_F00D);
    r_before = bus.o_retired;
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h1111_1111);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'h2222_2222);
    chk("idle_mem_no_count", bus.o_retired, r_before);

    // Reset in the middle of a memory wait
    cycle(1, 5'd13, 32'd0, 1, 3'b000, 2'd1, 0, 32'd0);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 0, 32'd0);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 1, 32'hFFFF_FFFF);
    cycle(0, 5'd0, 32'd0, 0, 3'd0, 2'd0, 0, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed at RV32 (32-bit data, 5-bit register index).
REQ-002 clk  input  1  single clock for all state; every flop is rising-edge triggered.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_valid  input  1  execute stage presents one completed instruction this cycle.
REQ-005 i_rd  input  5  destination register of the presented instruction.
REQ-006 i_result  input  32  ALU/jump-link result for non-load instructions.
REQ-007 i_is_load  input  1  presented instruction is a load.
REQ-008 i_funct3  input  3  load width/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 i_addr_lo  input  2  low two bits of the load effective address.
REQ-010 i_mem_valid  input  1  data memory returns load data this cycle.
REQ-011 i_mem_rdata  input  32  aligned 32-bit word returned by data memory.
REQ-012 o_wback  output  1  register-file write enable, one-cycle pulse.
REQ-013 o_wreg  output  5  register-file write index.
REQ-014 o_wdata  output  32  register-file write data.
REQ-015 o_stall  output  1  upstream hold; execute must keep its instruction stable while this is high.
REQ-016 o_retired  output  32  count of instructions retired since reset.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and WAIT_MEM.
REQ-018 IDLE, i_valid=1, i_is_load=0: SHALL register o_wreg=i_rd and o_wdata=i_result, and pulse o_wback for exactly the next cycle (1-cycle latency).
REQ-019 IDLE, i_valid=1, i_is_load=1: SHALL capture i_rd, i_funct3 and i_addr_lo, then enter WAIT_MEM; o_wback stays 0.
REQ-020 o_stall SHALL be combinationally 1 exactly while the state is WAIT_MEM; in WAIT_MEM, i_valid SHALL be ignored and nothing is accepted.
REQ-021 WAIT_MEM, i_mem_valid=1: SHALL register the formatted load data and the captured rd, pulse o_wback the next cycle, and return to IDLE in the same edge.
REQ-022 WAIT_MEM, i_mem_valid=0: SHALL remain in WAIT_MEM indefinitely; there is no timeout.
REQ-023 i_mem_valid in IDLE SHALL be ignored.
REQ-024 Load formatting, byte lane = i_addr_lo: LB/LBU select rdata[8*lane+7:8*lane], then sign-extend (LB) or zero-extend (LBU).
REQ-025 Load formatting, halfword: LH/LHU select rdata[31:16] when addr_lo[1]=1, else rdata[15:0]; addr_lo[0] is ignored; then sign-extend (LH) or zero-extend (LHU).
REQ-026 Load formatting, word: LW SHALL pass rdata unchanged; any unlisted funct3 SHALL also pass rdata unchanged.
REQ-027 rd=0: o_wback SHALL stay 0 and o_wreg/o_wdata SHALL hold their previous values; the instruction still counts as retired.
REQ-028 o_retired SHALL increment by 1 on each non-load acceptance and on each load completion; it wraps modulo 2^32.
REQ-029 While o_wback=0, o_wreg and o_wdata SHALL hold their last values.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, o_wback=0, o_wreg=0, o_wdata=0, o_retired=0 and o_stall=0.
REQ-031 Reset asserted during WAIT_MEM SHALL abandon the pending load with no writeback; a later i_mem_valid SHALL be ignored.

Verification
REQ-032 Non-load: i_valid, rd=5, result=0x1234 -> next cycle o_wback=1, o_wreg=5, o_wdata=0x1234; o_retired=1.
REQ-033 LB: addr_lo=3, rdata=0x80FF_0011, mem_valid 3 cycles after accept -> o_stall=1 for 3 cycles, then o_wdata=0xFFFF_FF80; LBU with the same inputs -> 0x0000_0080.
REQ-034 LH/LHU: addr_lo=2, rdata=0xFFFE_1234 -> LH 0xFFFF_FFFE, LHU 0x0000_FFFE; addr_lo=0 -> 0x0000_1234 for both.
REQ-035 rd=0 for both an ALU op and a load -> o_wback never asserts; o_retired advances by 2.
REQ-036 i_valid held high during WAIT_MEM, and i_mem_valid pulsed in IDLE -> no extra writebacks and no count change.
REQ-037 rst_n pulsed low mid-WAIT_MEM, then i_mem_valid=1 -> outputs zero, no o_wback, state IDLE.
